// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the fixed-latency pipelined ALU: drives operands, tracks in-flight ops, queues tagged responses.
// Optional ALU_SEQ_SGT_FIX_EN: carry operands down the delay line and compute signed-greater-than locally for opcode 7.
module alu_cmd_sequencer #(
  parameter int W     = 8,
  parameter int LAT   = 2,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_opcode,
  input  logic [W-1:0]     cmd_a,
  input  logic [W-1:0]     cmd_b,
  input  logic [4:0]       cmd_shift,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [3:0]       alu_opcode,
  output logic [W-1:0]     alu_input1,
  output logic [W-1:0]     alu_input2,
  output logic [4:0]       alu_shift,
  input  logic [W-1:0]     alu_result,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_result,
  output logic             rsp_carry,
  output logic             rsp_err,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
);

  localparam int NST = LAT + 1;
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int OW  = $clog2(DEPTH + NST + 1);

  typedef struct packed {
    logic [W-1:0]     result;
    logic             carry;
    logic             err;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  logic [3:0]       alu_opcode_q;
  logic [W-1:0]     alu_input1_q;
  logic [W-1:0]     alu_input2_q;
  logic [4:0]       alu_shift_q;

  logic [NST-1:0]   dv_q;
  logic [TAG_W-1:0] dtag_q [NST];
  logic [3:0]       dop_q  [NST];
`ifdef ALU_SEQ_SGT_FIX_EN
  logic [W-1:0]     da_q   [NST];
  logic [W-1:0]     db_q   [NST];
`endif

  rsp_t             mem_q  [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic             accept;
  logic             push;
  logic             pop;
  logic [OW-1:0]    occ;
  rsp_t             cap;
  rsp_t             head;

  assign accept = cmd_valid & cmd_ready;

  // Credit counts queued responses plus every op still in the delay line,
  // so a capture always finds a free FIFO slot.
  always_comb begin
    occ = OW'(count_q);
    for (int unsigned i = 0; i < NST; i++) begin
      occ = occ + OW'(dv_q[i]);
    end
  end

  assign cmd_ready = occ < OW'(DEPTH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_opcode_q <= '0;
      alu_input1_q <= '0;
      alu_input2_q <= '0;
      alu_shift_q  <= '0;
      dv_q         <= '0;
      for (int unsigned i = 0; i < NST; i++) begin
        dtag_q[i] <= '0;
        dop_q[i]  <= '0;
`ifdef ALU_SEQ_SGT_FIX_EN
        da_q[i]   <= '0;
        db_q[i]   <= '0;
`endif
      end
    end else begin
      if (accept) begin
        alu_opcode_q <= cmd_opcode;
        alu_input1_q <= cmd_a;
        alu_input2_q <= cmd_b;
        alu_shift_q  <= cmd_shift;
      end
      dv_q[0]   <= accept;
      dtag_q[0] <= cmd_tag;
      dop_q[0]  <= cmd_opcode;
`ifdef ALU_SEQ_SGT_FIX_EN
      da_q[0]   <= cmd_a;
      db_q[0]   <= cmd_b;
`endif
      for (int unsigned i = 1; i < NST; i++) begin
        dv_q[i]   <= dv_q[i-1];
        dtag_q[i] <= dtag_q[i-1];
        dop_q[i]  <= dop_q[i-1];
`ifdef ALU_SEQ_SGT_FIX_EN
        da_q[i]   <= da_q[i-1];
        db_q[i]   <= db_q[i-1];
`endif
      end
    end
  end

  assign alu_opcode = alu_opcode_q;
  assign alu_input1 = alu_input1_q;
  assign alu_input2 = alu_input2_q;
  assign alu_shift  = alu_shift_q;

  // The ALU holds its carry flag across non-arithmetic ops; mask it here.
  always_comb begin
    cap.result = alu_result;
    cap.carry  = alu_carry & (dop_q[NST-1] == 4'd0 || dop_q[NST-1] == 4'd1);
    cap.err    = dop_q[NST-1][3];
    cap.tag    = dtag_q[NST-1];
`ifdef ALU_SEQ_SGT_FIX_EN
    if (dop_q[NST-1] == 4'd7) begin
      cap.result = {{(W-1){1'b0}}, ($signed(da_q[NST-1]) > $signed(db_q[NST-1]))};
      cap.carry  = 1'b0;
    end
`endif
  end

  assign push = dv_q[NST-1];
  assign pop  = rsp_valid & rsp_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cap;
  end

  assign head       = mem_q[rd_ptr_q];
  assign rsp_valid  = (count_q != '0);
  assign rsp_result = head.result;
  assign rsp_carry  = head.carry;
  assign rsp_err    = head.err;
  assign rsp_tag    = head.tag;
  assign busy       = (|dv_q) | rsp_valid;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural 2-edge-latency ALU model.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [3:0] cmd_opcode;
  logic [7:0] cmd_a, cmd_b;
  logic [4:0] cmd_shift;
  logic [3:0] cmd_tag;
  logic [3:0] alu_opcode;
  logic [7:0] alu_input1, alu_input2;
  logic [4:0] alu_shift;
  logic [7:0] alu_result;
  logic       alu_carry;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_carry, rsp_err;
  logic [3:0] rsp_tag;
  logic       busy;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  alu_cmd_sequencer #(.W(8), .LAT(2), .DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_shift(cmd_shift), .cmd_tag(cmd_tag),
    .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2),
    .alu_shift(alu_shift), .alu_result(alu_result), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_err(rsp_err), .rsp_tag(rsp_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  // ALU model: two register stages; carry is held on non-ADD/SUB ops; SGT is an unsigned compare.
  logic [7:0] p1_r, p2_r;
  logic       p1_c, p2_c;
  logic [8:0] ext;
  always_comb begin
    case (alu_opcode)
      4'd0:    ext = {1'b0, alu_input1} + {1'b0, alu_input2};
      4'd1:    ext = {1'b0, alu_input1} - {1'b0, alu_input2};
      4'd2:    ext = {1'b0, alu_input1 * alu_input2};
      4'd3:    ext = {1'b0, alu_input1 | alu_input2};
      4'd4:    ext = {1'b0, alu_input1 & alu_input2};
      4'd5:    ext = {1'b0, alu_input1 ^ alu_input2};
      4'd6:    ext = {1'b0, ~(alu_input1 & alu_input2)};
      4'd7:    ext = {8'd0, alu_input1 > alu_input2};
      default: ext = 9'd0;
    endcase
  end
  always @(posedge clk) begin
    p1_r <= ext[7:0];
    p1_c <= (alu_opcode == 4'd0 || alu_opcode == 4'd1) ? ext[8] : p1_c;
    p2_r <= p1_r;
    p2_c <= p1_c;
  end
  assign alu_result = p2_r;
  assign alu_carry  = p2_c;
  initial begin p1_c = 1'b0; p2_c = 1'b0; p1_r = 8'd0; p2_r = 8'd0; end

  typedef struct packed {
    logic [7:0] r;
    logic       c;
    logic       e;
    logic [3:0] t;
  } rsp_t;
  rsp_t q[$];

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) q.push_back('{rsp_result, rsp_carry, rsp_err, rsp_tag});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_rsp(input string nm, input int idx, input logic [7:0] r,
                         input logic c, input logic e, input logic [3:0] t);
    if (idx >= q.size()) begin
      chk({nm, "_missing"}, 32'(q.size()), 32'(idx + 1));
    end else begin
      chk({nm, "_res"}, 32'(q[idx].r), 32'(r));
      chk({nm, "_cy"},  32'(q[idx].c), 32'(c));
      chk({nm, "_err"}, 32'(q[idx].e), 32'(e));
      chk({nm, "_tag"}, 32'(q[idx].t), 32'(t));
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] tg);
    int unsigned w;
    w = 0;
    cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_tag = tg;
    cmd_shift = 5'(tg);
    @(negedge clk);
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) chk("issue_timeout", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n);
    int unsigned w;
    w = 0;
    while (q.size() < n && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    chk("rsp_count", 32'(q.size()), 32'(n));
  endtask

  initial begin
    int unsigned n_acc;
    logic [7:0]  ta;
    rst = 1'b1; cmd_valid = 1'b0; cmd_opcode = '0; cmd_a = '0; cmd_b = '0;
    cmd_shift = '0; cmd_tag = '0; rsp_ready = 1'b0;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_alu_op", 32'(alu_opcode), 32'd0);
    chk("rst_alu_in1", 32'(alu_input1), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single ADD: latency check
    issue(4'd0, 8'hF0, 8'h20, 4'd3);
    chk("t1_alu_in1", 32'(alu_input1), 32'hF0);
    chk("t1_alu_shift", 32'(alu_shift), 32'd3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t1_valid_E2", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    chk("t1_valid_E3", 32'(rsp_valid), 32'd1);
    chk("t1_res", 32'(rsp_result), 32'h10);
    chk("t1_cy", 32'(rsp_carry), 32'd1);
    chk("t1_err", 32'(rsp_err), 32'd0);
    chk("t1_tag", 32'(rsp_tag), 32'd3);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("t1_drained", 32'(rsp_valid), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);
    q.delete();

    // Back-to-back stream
    rsp_ready = 1'b1;
    issue(4'd1, 8'd5,   8'd7,   4'd0);
    issue(4'd2, 8'd12,  8'd12,  4'd1);
    issue(4'd3, 8'h0F,  8'h30,  4'd2);
    issue(4'd4, 8'hF0,  8'h3C,  4'd3);
    issue(4'd5, 8'hAA,  8'h0F,  4'd4);
    issue(4'd6, 8'hFF,  8'h0F,  4'd5);
    issue(4'd0, 8'h80,  8'h80,  4'd6);
    issue(4'd1, 8'd9,   8'd2,   4'd7);
    wait_rsp(8);
    chk_rsp("b2b_sub", 0, 8'hFE, 1'b1, 1'b0, 4'd0);
    chk_rsp("b2b_mul", 1, 8'h90, 1'b0, 1'b0, 4'd1);
    chk_rsp("b2b_or",  2, 8'h3F, 1'b0, 1'b0, 4'd2);
    chk_rsp("b2b_and", 3, 8'h30, 1'b0, 1'b0, 4'd3);
    chk_rsp("b2b_xor", 4, 8'hA5, 1'b0, 1'b0, 4'd4);
    chk_rsp("b2b_nand",5, 8'hF0, 1'b0, 1'b0, 4'd5);
    chk_rsp("b2b_add", 6, 8'h00, 1'b1, 1'b0, 4'd6);
    chk_rsp("b2b_sub2",7, 8'h07, 1'b0, 1'b0, 4'd7);
    q.delete();

    // Backpressure: exactly DEPTH accepts, then drain in order
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    n_acc = 0; ta = 8'h10;
    cmd_valid = 1'b1; cmd_opcode = 4'd0; cmd_a = ta; cmd_b = 8'd1; cmd_tag = 4'd8;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (cmd_ready) begin
        n_acc++;
        @(posedge clk); #1;
        ta = ta + 8'd1; cmd_a = ta; cmd_tag = cmd_tag + 4'd1;
      end else begin
        @(posedge clk); #1;
      end
    end
    cmd_valid = 1'b0;
    chk("bp_accepts", 32'(n_acc), 32'd4);
    chk("bp_ready_low", 32'(cmd_ready), 32'd0);
    chk("bp_busy", 32'(busy), 32'd1);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_ready_back", 32'(cmd_ready), 32'd1);
    wait_rsp(4);
    for (int k = 0; k < 4; k++) chk_rsp("bp", k, 8'(8'h11 + k), 1'b0, 1'b0, 4'(8 + k));
    q.delete();

    // Error opcode and carry masking
    issue(4'd9, 8'd3,   8'd4,   4'd1);
    issue(4'd0, 8'hFF,  8'h01,  4'd2);
    issue(4'd4, 8'hFF,  8'h0F,  4'd3);
    wait_rsp(3);
    chk_rsp("err", 0, 8'h00, 1'b0, 1'b1, 4'd1);
    chk_rsp("add_cy", 1, 8'h00, 1'b1, 1'b0, 4'd2);
    chk_rsp("and_mask", 2, 8'h0F, 1'b0, 1'b0, 4'd3);
    q.delete();

    // Opcode 7
    issue(4'd7, 8'h05, 8'hFB, 4'd4);
    issue(4'd7, 8'h80, 8'h01, 4'd5);
    wait_rsp(2);
`ifdef ALU_SEQ_SGT_FIX_EN
    chk_rsp("sgt_pos", 0, 8'h01, 1'b0, 1'b0, 4'd4);
    chk_rsp("sgt_neg", 1, 8'h00, 1'b0, 1'b0, 4'd5);
`else
    chk_rsp("sgt_raw0", 0, 8'h00, 1'b0, 1'b0, 4'd4);
    chk_rsp("sgt_raw1", 1, 8'h01, 1'b0, 1'b0, 4'd5);
`endif
    q.delete();

    // Reset with two in flight and one queued
    rsp_ready = 1'b0;
    issue(4'd0, 8'd1, 8'd1, 4'd1);
    repeat (4) begin @(posedge clk); #1; end
    issue(4'd0, 8'd2, 8'd2, 4'd2);
    issue(4'd0, 8'd3, 8'd3, 4'd3);
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_valid", 32'(rsp_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mrst_valid", 32'(rsp_valid), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_ready", 32'(cmd_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rsp_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("post_rst_no_rsp", 32'(q.size()), 32'd0);
    chk("post_rst_valid", 32'(rsp_valid), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
